fft_result_unloader: RTL
========================

Name: fft_result_unloader

Overview:
- Sits directly downstream of the FFT core.
- Once the core signals completion, it reads the finished transform out of the shared 128-bit sample SRAM, one word at a time in order.
- It splits each word into four 32-bit complex samples and streams them out over a valid/ready interface to the host or output port.
- It prefetches up to two words ahead, so the stream runs at one sample per cycle while the sink is ready.

Parameters:
- ADDR_W, 8, SRAM word address width (maximum 256 words).
- LANES, 4, samples per SRAM word.
- SAMPLE_W, 32, bits per sample: {real[31:16], imag[15:0]}, both two's complement.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- i_start  in  1  single-cycle start pulse; normally wired to the FFT core's done output.
- i_point_config  in  3  transform size select; samples N = 16 << cfg; values 7 and above are treated as 6 (N = 1024).
- o_raddress  out  ADDR_W  SRAM read address.
- o_ren  out  1  SRAM read request; i_rdata returns exactly 1 cycle later.
- i_rdata  in  LANES*SAMPLE_W  SRAM read data.
- o_sample  out  SAMPLE_W  output sample.
- o_sample_valid  out  1  o_sample is valid.
- i_sample_ready  in  1  sink accepts the sample.
- o_last  out  1  marks the final sample of the transform; qualified by o_sample_valid.
- o_busy  out  1  high from the cycle after i_start until the last sample is accepted.
- o_done  out  1  1-cycle pulse on the cycle after the last handshake.

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous, active-low.
- Reset values: all outputs 0, including o_raddress. State is IDLE, all counters 0, word buffer empty.
- States: IDLE and RUN.
  - IDLE -> RUN on i_start. On that edge, i_point_config is latched and words_total = N/4 (4..256) is computed.
  - i_start is ignored while in RUN.
  - RUN -> IDLE on the handshake of the last sample (o_sample_valid & i_sample_ready & o_last). o_done pulses on the following cycle.
- Read issue:
  - rd_cnt runs 0..words_total-1.
  - o_ren is asserted in RUN only when (buffered words + reads in flight) < 2 and rd_cnt < words_total.
  - o_raddress = rd_cnt while o_ren is high; it holds its last value otherwise.
  - rd_cnt uses ADDR_W+1 bits so that a count of 256 does not wrap to 0.
- Capture: i_rdata is written into a 2-entry word FIFO on the cycle after each o_ren. No other cycle writes the FIFO.
- Unpack:
  - o_sample_valid = FIFO not empty.
  - o_sample = head word lane[lane_cnt]; lane 0 is bits [31:0], lane 3 is bits [127:96].
  - On each handshake, lane_cnt increments. When it wraps 3 -> 0, the head word is popped.
  - o_sample and o_sample_valid are stable while valid is high and ready is low.
- o_last is high when the sample counter equals N-1 and valid is high.
- Throughput: the first sample appears 2 cycles after i_start (1 cycle to RUN plus 1 cycle of SRAM latency). After that, 1 sample per cycle while ready is held high, with no bubbles at word boundaries.
- Backpressure: with ready held low indefinitely, reads stop after 2 words are outstanding. No data is lost or duplicated.
- Reset mid-operation: rstn low returns the block to IDLE immediately, clears the FIFO, clears all counters, and drops o_ren, o_busy and o_sample_valid.
- i_start in the same cycle as o_done: the block restarts. It re-enters RUN on the next cycle, and o_done still pulses.

Optional Feature:
- Macro: UNLOAD_BITREV_EN.
- When defined: o_raddress = rd_cnt with its low log2(words_total) bits bit-reversed, so words are read in bit-reversed word order. Lane order within each word is unchanged.
  - Example: for N = 32 (8 words), the read address sequence is 0, 4, 2, 6, 1, 5, 3, 7.
- When undefined: natural order 0..words_total-1. No bit-reversal logic is present.

Test Plan:
- Reset with all inputs idle -> all outputs 0. Asserting rstn low mid-RUN -> o_busy and o_sample_valid are 0 in the same cycle, and the block is in IDLE.
- cfg = 0, word k holds lane i = {k*4+i}, ready held high, i_start at cycle 0 -> o_sample_valid rises at cycle 2; samples 0..15 arrive on consecutive cycles; o_last is high on sample 15; o_done pulses at cycle 18; o_busy is high for cycles 1..17.
- cfg = 6 (N = 1024), ready held high -> addresses 0..255 are each read exactly once; 1024 samples arrive in order; no gaps after the first sample.
- cfg = 1, ready toggling 1-0-1-0, then held low for 20 cycles -> at most 2 words are outstanding during the stall; the sample sequence 0..31 is intact; o_sample is stable while stalled.
- cfg = 7 -> same behaviour as cfg = 6 (1024 samples). i_start pulsed mid-RUN -> ignored; the sample count stays 1024.
- With UNLOAD_BITREV_EN defined and cfg = 1 -> the read address sequence is 0, 4, 2, 6, 1, 5, 3, 7. Without the macro -> 0..7.

Source files
------------

// File: rtl/fft_result_unloader_if.sv
`default_nettype none
// =====================================================================
// fft_result_unloader_if
// Start/config, SRAM read port and sample stream of the result unloader.
// Revision: 1.0
// =====================================================================
interface fft_result_unloader_if #(
  parameter int ADDR_W   = 8,
  parameter int LANES    = 4,
  parameter int SAMPLE_W = 32
);
  logic                      i_start;
  logic [2:0]                i_point_config;
  logic [ADDR_W-1:0]         o_raddress;
  logic                      o_ren;
  logic [LANES*SAMPLE_W-1:0] i_rdata;
  logic [SAMPLE_W-1:0]       o_sample;
  logic                      o_sample_valid;
  logic                      i_sample_ready;
  logic                      o_last;
  logic                      o_busy;
  logic                      o_done;

  modport master (
    input  i_start, i_point_config, i_rdata, i_sample_ready,
    output o_raddress, o_ren, o_sample, o_sample_valid, o_last, o_busy, o_done
  );

  modport slave (
    output i_start, i_point_config, i_rdata, i_sample_ready,
    input  o_raddress, o_ren, o_sample, o_sample_valid, o_last, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/fft_result_unloader.sv
`default_nettype none
// =====================================================================
// fft_result_unloader
// Reads a finished transform out of the sample SRAM and streams it as one
// complex sample per cycle. Macro UNLOAD_BITREV_EN: bit-reversed word order.
// Revision: 1.0
// =====================================================================
module fft_result_unloader #(
  parameter int ADDR_W   = 8,
  parameter int LANES    = 4,
  parameter int SAMPLE_W = 32
) (
  input wire                    clk,
  input wire                    rstn,
  fft_result_unloader_if.master bus
);
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int SMP_W  = ADDR_W + LANE_W;
  localparam int WORD_W = LANES * SAMPLE_W;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic [CNT_W-1:0]  words_total;
  logic [CNT_W-1:0]  rd_cnt;
  logic [SMP_W-1:0]  last_idx;
  logic [SMP_W-1:0]  smp_cnt;
  logic [LANE_W-1:0] lane_cnt;
  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic              pend;
  logic              done;
  logic [1:0]        fifo_cnt;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [WORD_W-1:0] fifo_mem [2];

  logic [2:0]                     cfg_eff;
  logic [CNT_W-1:0]               words_nx;
  logic [SMP_W-1:0]               last_nx;
  logic [LANES-1:0][SAMPLE_W-1:0] head;
  logic                           valid;
  logic                           hs;
  logic                           pop;
  logic                           last;
  logic [1:0]                     cnt_nx;
  logic                           can_issue;
  logic [ADDR_W-1:0]              issue_addr;

  assign cfg_eff  = (bus.i_point_config > 3'd6) ? 3'd6 : bus.i_point_config;
  assign words_nx = CNT_W'((32'd16 << cfg_eff) / LANES);
  assign last_nx  = SMP_W'((32'd16 << cfg_eff) - 32'd1);

  // The FIFO is write-through: the word arriving from the SRAM this cycle
  // is already the head when nothing older is buffered.
  assign head  = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] : bus.i_rdata;
  assign valid = (fifo_cnt != 2'd0) || pend;
  assign hs    = valid && bus.i_sample_ready;
  assign pop   = hs && (lane_cnt == LANE_W'(LANES - 1));
  assign last  = valid && (smp_cnt == last_idx);

  // Occupancy after this edge plus any read issued now must leave room.
  assign cnt_nx    = fifo_cnt + {1'b0, pend} - {1'b0, pop};
  assign can_issue = (state == RUN) && (rd_cnt < words_total) &&
                     (({1'b0, cnt_nx} + {2'b00, ren}) < 3'd2);

`ifdef UNLOAD_BITREV_EN
  logic [2:0]        cfg_q;
  logic [ADDR_W-1:0] rev;

  always_comb begin
    rev = '0;
    for (int b = 0; b < ADDR_W; b++) rev[b] = rd_cnt[ADDR_W-1-b];
  end

  // rd_cnt < words_total, so a full-width reverse puts the live bits on top.
  assign issue_addr = rev >> (ADDR_W + LANE_W - 4 - int'(cfg_q));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          cfg_q <= '0;
    else if (state == IDLE && bus.i_start) cfg_q <= cfg_eff;
  end
`else
  assign issue_addr = rd_cnt[ADDR_W-1:0];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      words_total <= '0;
      rd_cnt      <= '0;
      last_idx    <= '0;
      smp_cnt     <= '0;
      lane_cnt    <= '0;
      raddr       <= '0;
      ren         <= 1'b0;
      pend        <= 1'b0;
      done        <= 1'b0;
      fifo_cnt    <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      done     <= 1'b0;
      pend     <= ren;
      fifo_cnt <= cnt_nx;
      if (pend) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case (state)
        IDLE: begin
          ren <= 1'b0;
          if (bus.i_start) begin
            state       <= RUN;
            words_total <= words_nx;
            last_idx    <= last_nx;
            rd_cnt      <= CNT_W'(1);
            ren         <= 1'b1;
            raddr       <= '0;
            lane_cnt    <= '0;
            smp_cnt     <= '0;
          end
        end
        RUN: begin
          if (hs) begin
            lane_cnt <= lane_cnt + 1'b1;
            smp_cnt  <= smp_cnt + 1'b1;
          end
          if (can_issue) begin
            ren    <= 1'b1;
            raddr  <= issue_addr;
            rd_cnt <= rd_cnt + 1'b1;
          end else begin
            ren <= 1'b0;
          end
          if (hs && last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pend) fifo_mem[wr_ptr] <= bus.i_rdata;
  end

  assign bus.o_ren          = ren;
  assign bus.o_raddress     = raddr;
  assign bus.o_sample_valid = valid;
  assign bus.o_sample       = valid ? head[lane_cnt] : '0;
  assign bus.o_last         = last;
  assign bus.o_busy         = (state == RUN);
  assign bus.o_done         = done;
endmodule
`default_nettype wire
